canvas_port_sched: RTL and testbench



---
 rtl/canvas_port_sched_if.sv | 62 ++++++
 rtl/canvas_port_sched.sv | 158 +++++++++++++++
 tb/tb_canvas_port_sched.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/canvas_port_sched_if.sv
// canvas_port_sched_if
//   Bundles every non-clock, non-reset signal of canvas_port_sched.
//   Parameter: ADDR_W (canvas RAM address width).
//
//   Signal summary (direction as seen from the scheduler, modport slave):
//     clr_req      in   1-cycle pulse, request full-canvas clear
//     rd_req       in   1-cycle pulse, request full-canvas raster read-out
//     draw_valid   in   pixel write request
//     draw_addr    in   pixel address {y[4:0],x[4:0]}
//     draw_data    in   pixel value
//     draw_ready   out  pixel write accepted this cycle when draw_valid & draw_ready
//     mem_addr     out  RAM address
//     mem_we       out  RAM write enable
//     mem_wdata    out  RAM write data
//     mem_rdata    in   RAM read data, valid one cycle after mem_addr
//     rd_bit_valid out  read-out bit strobe
//     rd_bit       out  read-out bit, raster order, address 0 first
//     rd_done      out  pulse coincident with the last rd_bit_valid
//     clr_done     out  pulse in the cycle after the last clear write
//     busy         out  scheduler not idle, or a request is pending
//     canvas_dirty out  a 1-pixel was drawn since the last clear (optional feature)
//     state_dbg    out  scheduler state: 0 IDLE, 1 CLEAR, 2 READ, 3 RTAIL
//
//   Handshake: a pixel write transfers in every cycle where draw_valid and
//   draw_ready are both high. Once draw_valid is raised, the front end holds it,
//   and holds draw_addr/draw_data stable, until that transfer cycle. draw_ready
//   does not depend on draw_valid.
//
//   The master modport is the environment side: front end, request source and RAM.
interface canvas_port_sched_if #(
  parameter int ADDR_W = 10
);
  logic              clr_req;
  logic              rd_req;
  logic              draw_valid;
  logic [ADDR_W-1:0] draw_addr;
  logic              draw_data;
  logic              draw_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic              mem_wdata;
  logic              mem_rdata;
  logic              rd_bit_valid;
  logic              rd_bit;
  logic              rd_done;
  logic              clr_done;
  logic              busy;
  logic              canvas_dirty;
  logic [1:0]        state_dbg;

  modport master (
    output clr_req, rd_req, draw_valid, draw_addr, draw_data, mem_rdata,
    input  draw_ready, mem_addr, mem_we, mem_wdata, rd_bit_valid, rd_bit,
           rd_done, clr_done, busy, canvas_dirty, state_dbg
  );

  modport slave (
    input  clr_req, rd_req, draw_valid, draw_addr, draw_data, mem_rdata,
    output draw_ready, mem_addr, mem_we, mem_wdata, rd_bit_valid, rd_bit,
           rd_done, clr_done, busy, canvas_dirty, state_dbg
  );
endinterface

// File: rtl/canvas_port_sched.sv
// canvas_port_sched
//   Sole owner of the single port of the 1-bit canvas bitmap RAM (32x32 canvas).
//   Three users share the port:
//     - a full-canvas clear sweep, which writes 0 to every cell;
//     - pixel writes from the line-drawing front end, using valid/ready;
//     - a full-canvas raster read-out, which streams the bitmap to the recognizer.
//   Pixel writes are accepted only while idle with no sweep pending. Clear and read
//   requests are latched as pending flags, and repeated requests merge. When both
//   are pending, clear goes first. A running sweep is never cut short.
//
//   Parameters: ADDR_W (RAM address width), DEPTH (cells swept, <= 2**ADDR_W).
//   Ports: clk, rst (synchronous, active high), and bus (canvas_port_sched_if.slave).
//   See the interface file for the signal summary.
//
//   Optional feature, macro CANVAS_DIRTY_EN:
//     defined   -> canvas_dirty is a flop. It is set by an accepted draw of a 1
//                  pixel and cleared by reset or by the clr_done cycle.
//     undefined -> canvas_dirty is tied to 0.
module canvas_port_sched #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  canvas_port_sched_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    READ  = 2'd2,
    RTAIL = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);

  state_t          state;
  logic [ADDR_W:0] cnt;        // one bit wider than an address so DEPTH never wraps
  logic            clr_pend;
  logic            rd_pend;
  logic            rd_vld_q;   // an address was issued in READ last cycle
  logic            clr_done_q;
  logic            draw_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      clr_pend   <= 1'b0;
      rd_pend    <= 1'b0;
      rd_vld_q   <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      rd_vld_q   <= (state == READ);
      clr_done_q <= 1'b0;
      // Requests are latched in every state. The clear on sweep entry below
      // comes later in this block, so it wins, which merges a request that
      // arrives while its sweep is starting.
      if (bus.clr_req) clr_pend <= 1'b1;
      if (bus.rd_req)  rd_pend  <= 1'b1;
      case (state)
        IDLE: begin
          if (clr_pend) begin
            state    <= CLEAR;
            cnt      <= '0;
            clr_pend <= 1'b0;
          end else if (rd_pend) begin
            state   <= READ;
            cnt     <= '0;
            rd_pend <= 1'b0;
          end
        end
        CLEAR: begin
          if (cnt == LAST) begin
            state      <= IDLE;
            cnt        <= '0;
            clr_done_q <= 1'b1;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        READ: begin
          if (cnt == LAST) begin
            state <= RTAIL;
            cnt   <= '0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        RTAIL: begin
          // The RAM returns the data for the final address during this cycle.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pending flags are only visible one cycle after the request pulse. The front
  // end can therefore see ready in the same cycle a request arrives. The write it
  // makes in that cycle lands before the sweep starts.
  assign draw_ready = (state == IDLE) && !clr_pend && !rd_pend;

  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = 1'b0;
    case (state)
      IDLE: begin
        if (bus.draw_valid && draw_ready) begin
          bus.mem_addr  = bus.draw_addr;
          bus.mem_we    = 1'b1;
          bus.mem_wdata = bus.draw_data;
        end
      end
      CLEAR: begin
        bus.mem_addr = cnt[ADDR_W-1:0];
        bus.mem_we   = 1'b1;
      end
      READ: begin
        bus.mem_addr = cnt[ADDR_W-1:0];
      end
      default: ;
    endcase
  end

  assign bus.draw_ready   = draw_ready;
  assign bus.rd_bit_valid = rd_vld_q;
  // The RAM output register supplies the data. The strobe is qualified so that
  // rd_bit stays 0 outside the read-out.
  assign bus.rd_bit       = rd_vld_q & bus.mem_rdata;
  assign bus.rd_done      = (state == RTAIL);
  assign bus.clr_done     = clr_done_q;
  assign bus.busy         = (state != IDLE) || clr_pend || rd_pend;
  assign bus.state_dbg    = state;

`ifdef CANVAS_DIRTY_EN
  logic dirty_q;

  // A 1-pixel accepted in the clr_done cycle lands after the sweep. In that case
  // the canvas really is dirty, so set takes priority over the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      dirty_q <= 1'b0;
    end else if (bus.draw_valid && draw_ready && bus.draw_data) begin
      dirty_q <= 1'b1;
    end else if (clr_done_q) begin
      dirty_q <= 1'b0;
    end
  end

  assign bus.canvas_dirty = dirty_q;
`else
  assign bus.canvas_dirty = 1'b0;
`endif

endmodule

// File: tb/tb_canvas_port_sched.sv
// tb_canvas_port_sched
//   Directed bench for canvas_port_sched with a 1-bit RAM model attached.
//   The canvas model holds a shadow bitmap and expected-event queues. Every
//   cycle, the compare step checks write traffic, read-out bits, rd_done,
//   clr_done and canvas_dirty against the model. Literal cycle numbers pin the
//   latencies.
module tb_canvas_port_sched;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  canvas_port_sched_if #(.ADDR_W(ADDR_W)) bus();

  canvas_port_sched #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Canvas RAM: synchronous write, registered read, one cycle of latency.
  logic ram [0:DEPTH-1];
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  // ---------------- model / scoreboard ----------------
  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [ADDR_W:0] exp_q[$];    // expected RAM writes {addr, data}
  logic [1:0]      rd_q[$];     // expected read-out {is_last, bit}
  int              cd_exp = 0;  // clr_done pulses still owed
  logic            shadow [0:DEPTH-1];
  logic            m_dirty = 1'b0;

  int              s_cyc;
  logic            s_we, s_wdata, s_ready, s_busy, s_rvalid, s_rbit;
  logic            s_rdone, s_cdone, s_dirty, s_rst;
  logic [ADDR_W-1:0] s_addr;
  logic [1:0]      s_state;

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, s_cyc);
    end
  endtask

  task automatic model_clear(input int n, input bit completes);
    for (int a = 0; a < n; a++) begin
      exp_q.push_back({a[ADDR_W-1:0], 1'b0});
      shadow[a] = 1'b0;
    end
    if (completes) cd_exp++;
  endtask

  task automatic model_draw(input int addr, input logic data);
    exp_q.push_back({addr[ADDR_W-1:0], data});
    shadow[addr] = data;
  endtask

  task automatic model_read();
    for (int a = 0; a < DEPTH; a++) rd_q.push_back({a == DEPTH - 1, shadow[a]});
  endtask

  task automatic sb_check();
    logic [ADDR_W:0] e;
    logic [1:0]      r;
    if (s_we) begin
      if (exp_q.size() == 0) chk("write_expected", 0, 1);
      else begin
        e = exp_q.pop_front();
        chk("wr_addr", int'(s_addr), int'(e[ADDR_W:1]));
        chk("wr_data", int'(s_wdata), int'(e[0]));
      end
    end
    if (s_rvalid) begin
      if (rd_q.size() == 0) chk("rd_expected", 0, 1);
      else begin
        r = rd_q.pop_front();
        chk("rd_bit", int'(s_rbit), int'(r[0]));
        chk("rd_done", int'(s_rdone), int'(r[1]));
      end
    end else begin
      chk("rd_done_without_bit", int'(s_rdone), 0);
    end
    if (s_cdone) begin
      chk("clr_done_expected", int'(cd_exp > 0), 1);
      if (cd_exp > 0) cd_exp--;
    end
`ifdef CANVAS_DIRTY_EN
    chk("canvas_dirty", int'(s_dirty), int'(m_dirty));
    if (s_rst) m_dirty = 1'b0;
    else if (s_we && s_ready && s_wdata) m_dirty = 1'b1;
    else if (s_cdone) m_dirty = 1'b0;
`else
    chk("canvas_dirty", int'(s_dirty), 0);
`endif
  endtask

  // Sample the current cycle at the falling edge, then move to the drive point
  // of the next cycle.
  task automatic tick();
    @(negedge clk);
    s_cyc = cyc; s_we = bus.mem_we; s_wdata = bus.mem_wdata; s_addr = bus.mem_addr;
    s_ready = bus.draw_ready; s_busy = bus.busy; s_rvalid = bus.rd_bit_valid;
    s_rbit = bus.rd_bit; s_rdone = bus.rd_done; s_cdone = bus.clr_done;
    s_dirty = bus.canvas_dirty; s_rst = rst; s_state = bus.state_dbg;
    sb_check();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic draw(input int addr, input logic data);
    bus.draw_valid = 1'b1; bus.draw_addr = addr[ADDR_W-1:0]; bus.draw_data = data;
    model_draw(addr, data);
    tick();
    chk("draw_accept", int'(s_we && s_ready), 1);
    bus.draw_valid = 1'b0;
  endtask

  task automatic run_read(input int budget, output int n_str, output int n_one,
                          output int one_idx, output int done_c, output int cd_c,
                          output int n_we);
    n_str = 0; n_one = 0; one_idx = -1; done_c = -1; cd_c = -1; n_we = 0;
    for (int i = 0; i < budget && done_c < 0; i++) begin
      tick();
      if (s_we) n_we++;
      if (s_cdone) cd_c = s_cyc;
      if (s_rvalid) begin
        if (s_rbit) begin n_one++; one_idx = n_str; end
        n_str++;
      end
      if (s_rdone) done_c = s_cyc;
    end
    chk("rd_done_seen", int'(done_c >= 0), 1);
  endtask

  // ---------------- stimulus ----------------
  int t0, first_we, n_we, done_c, cd_c, bad_ready, bad_busy, acc_c, rdone_c;
  int n_str, n_one, one_idx, n_cd;

  initial begin
    rst = 1'b1;
    bus.clr_req = 1'b0; bus.rd_req = 1'b0; bus.draw_valid = 1'b0;
    bus.draw_addr = '0; bus.draw_data = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    tick();
    chk("reset_draw_ready", int'(s_ready), 1);
    chk("reset_mem_we", int'(s_we), 0);
    chk("reset_busy", int'(s_busy), 0);
    chk("reset_rd_bit_valid", int'(s_rvalid), 0);
    chk("reset_clr_done", int'(s_cdone), 0);
    chk("reset_state_idle", int'(s_state), 0);

    // T1: full clear, with exact timing
    bus.clr_req = 1'b1; t0 = cyc; model_clear(DEPTH, 1'b1);
    tick();
    bus.clr_req = 1'b0;
    first_we = -1; n_we = 0; done_c = -1; bad_ready = 0; bad_busy = 0;
    for (int i = 0; i < 1200 && done_c < 0; i++) begin
      tick();
      if (s_we) begin n_we++; if (first_we < 0) first_we = s_cyc; end
      if (s_cdone) done_c = s_cyc;
      else begin
        if (s_ready) bad_ready++;
        if (!s_busy) bad_busy++;
      end
    end
    chk("t1_first_write_cycle", first_we - t0, 2);
    chk("t1_write_count", n_we, 1024);
    chk("t1_clr_done_cycle", done_c - t0, 1026);
    chk("t1_ready_low_cycles", bad_ready, 0);
    chk("t1_busy_low_cycles", bad_busy, 0);

    // T2: accept a pixel in the same cycle while idle
    bus.draw_valid = 1'b1; bus.draw_addr = 10'h123; bus.draw_data = 1'b1;
    model_draw(32'h123, 1'b1);
    tick();
    chk("t2_mem_we", int'(s_we), 1);
    chk("t2_mem_addr", int'(s_addr), 32'h123);
    chk("t2_mem_wdata", int'(s_wdata), 1);
    chk("t2_draw_ready", int'(s_ready), 1);
    bus.draw_valid = 1'b0;
    tick();
    chk("t2_idle_no_write", int'(s_we), 0);
`ifdef CANVAS_DIRTY_EN
    chk("t2_dirty_set", int'(s_dirty), 1);
`endif

    // T3: only cell 5 set, then read-out
    draw(32'h123, 1'b0);
    draw(5, 1'b1);
    bus.rd_req = 1'b1; t0 = cyc; model_read();
    tick();
    bus.rd_req = 1'b0;
    run_read(1200, n_str, n_one, one_idx, done_c, cd_c, n_we);
    chk("t3_strobes", n_str, 1024);
    chk("t3_ones", n_one, 1);
    chk("t3_one_index", one_idx, 5);
    chk("t3_rd_done_cycle", done_c - t0, 1026);
    chk("t3_no_writes", n_we, 0);

    // T4: clear and read requested in the same cycle
    draw(1023, 1'b1);
    bus.clr_req = 1'b1; bus.rd_req = 1'b1; t0 = cyc;
    model_clear(DEPTH, 1'b1); model_read();
    tick();
    bus.clr_req = 1'b0; bus.rd_req = 1'b0;
    run_read(2300, n_str, n_one, one_idx, done_c, cd_c, n_we);
    chk("t4_clr_done_cycle", cd_c - t0, 1026);
    chk("t4_writes", n_we, 1024);
    chk("t4_strobes", n_str, 1024);
    chk("t4_ones", n_one, 0);
    chk("t4_rd_done_cycle", done_c - t0, 2051);

    // T5: clear requested mid-read at cnt=500, with a draw held through both sweeps
    draw(7, 1'b1);
    draw(1023, 1'b1);
    bus.rd_req = 1'b1; t0 = cyc; model_read();
    tick();
    bus.rd_req = 1'b0;
    repeat (501) tick();
    bus.clr_req = 1'b1;
    bus.draw_valid = 1'b1; bus.draw_addr = 10'h2AA; bus.draw_data = 1'b1;
    model_clear(DEPTH, 1'b1); model_draw(32'h2AA, 1'b1);
    tick();
    chk("t5_busy_mid_read", int'(s_busy), 1);
    chk("t5_ready_mid_read", int'(s_ready), 0);
    bus.clr_req = 1'b0;
    acc_c = -1; rdone_c = -1; cd_c = -1;
    for (int i = 0; i < 2000 && acc_c < 0; i++) begin
      tick();
      if (s_rdone) rdone_c = s_cyc;
      if (s_cdone) cd_c = s_cyc;
      if (s_we && s_ready) acc_c = s_cyc;
    end
    bus.draw_valid = 1'b0;
    chk("t5_rd_done_cycle", rdone_c - t0, 1026);
    chk("t5_clr_done_cycle", cd_c - t0, 2052);
    chk("t5_draw_accept_cycle", acc_c - t0, 2052);
    tick();

    // T6: reset at CLEAR cnt=300 aborts the sweep
    draw(10, 1'b1);
    draw(900, 1'b1);
    bus.clr_req = 1'b1; t0 = cyc; model_clear(301, 1'b0);
    tick();
    bus.clr_req = 1'b0;
    repeat (301) tick();
    rst = 1'b1;
    tick();
    chk("t6_last_write_addr", int'(s_addr), 300);
    rst = 1'b0;
    tick();
    chk("t6_mem_we", int'(s_we), 0);
    chk("t6_busy", int'(s_busy), 0);
    chk("t6_draw_ready", int'(s_ready), 1);
    chk("t6_state_idle", int'(s_state), 0);
    n_cd = 0;
    repeat (900) begin
      tick();
      if (s_cdone) n_cd++;
    end
    chk("t6_no_clr_done", n_cd, 0);

    // T7: read-out after the aborted clear shows the surviving pixels
    bus.rd_req = 1'b1; model_read();
    tick();
    bus.rd_req = 1'b0;
    run_read(1200, n_str, n_one, one_idx, done_c, cd_c, n_we);
    chk("t7_strobes", n_str, 1024);
    chk("t7_ones", n_one, 2);
    chk("t7_last_one_index", one_idx, 900);
    tick();

    // All expected traffic was observed
    chk("end_writes_left", exp_q.size(), 0);
    chk("end_bits_left", rd_q.size(), 0);
    chk("end_clr_done_left", cd_exp, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
